ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, fed directly by the ID/EX register.
//  Decodes ALU control, computes the ALU result, zero flag, branch target and write-register select.
//  Registers all of that into the EX/MEM pipeline outputs.
//  MUL is iterative and multi-cycle; while it runs, this block stalls ID/EX and inserts bubbles into EX/MEM.
// PARAMETERS
//  WIDTH   32  datapath width; MUL takes WIDTH iterations
//  RW      5   register-index width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  iValid       in   1      ID/EX holds a real instruction (0 = bubble)
//  iFlush       in   1      taken branch resolved in MEM: kill current EX work
//  iRegWrite/iMemToReg/iMemWrite/iMemRead/iBranch  in 1 each  control bits from ID/EX
//  iAluOP       in   3      000 add, 001 sub, 010 R-type (funct), 011 and, 100 or, 101 slt, 11x add
//  iALUSrc      in   1      1 = operand B is iSignExtend, 0 = iData2
//  iRegDst      in   1      1 = dest iInstr1511, 0 = dest iInstr2016
//  iAddPC, iData1, iData2, iSignExtend  in WIDTH  PC+4, rs value, rt value, sign-extended imm
//  iInstr2016, iInstr1511  in RW  rt and rd indices
//  oStall       out  1      combinational; ID/EX and earlier stages must hold while 1
//  oValid, oRegWrite, oMemToReg, oMemWrite, oMemRead, oBranch  out 1 each  EX/MEM control
//  oBranchAddr  out  WIDTH  iAddPC + (iSignExtend << 2), modulo 2^WIDTH
//  oZero        out  1      ALU result == 0
//  oAluResult   out  WIDTH  ALU / MUL result
//  oData2       out  WIDTH  iData2 passthrough (store data)
//  oWriteReg    out  RW     selected destination index
// BEHAVIOUR
//  Reset: state IDLE, counter 0, oStall 0. All registered outputs are 0.
//  rst takes priority over everything, including mid-MUL; an in-flight MUL is discarded.
//  Bubble: every oValid/control output = 0. Data outputs hold their previous values (don't-care).
//  R-type funct = iSignExtend[5:0]:
//    100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor,
//    101010 slt (signed), 011000 MUL (low WIDTH bits of signed product).
//  Any other funct gives result 0; control bits pass through.
//  Add/sub wrap modulo 2^WIDTH; no overflow trap. slt result is {WIDTH-1 zeros, lt}.
//  FSM IDLE:
//    - iFlush=1 or iValid=0 -> bubble into EX/MEM at the next edge.
//    - Non-MUL valid instruction -> EX/MEM loaded at the next edge (1-cycle latency), oStall=0.
//    - Valid MUL -> oStall=1. At the edge: latch operands/control, cnt=0, EX/MEM gets a bubble, go MUL.
//  FSM MUL: one shift-add iteration per cycle, cnt increments.
//    - oStall=1 while cnt < WIDTH-1, and EX/MEM gets a bubble at each edge.
//    - cnt == WIDTH-1 (last iteration): oStall=0. At the edge, product + latched control go to EX/MEM, go IDLE.
//    - The ID/EX advance and the EX/MEM result load happen on the same edge.
//    - MUL occupancy = WIDTH+1 cycles from first presentation to result visible.
//    - oWriteReg for MUL = latched rd. oData2 = latched rt value.
//  iFlush in MUL (any cycle, including the last) -> abort to IDLE, EX/MEM bubble, oStall=0 that cycle.
//  iFlush and a valid non-MUL in IDLE together -> flush wins (bubble).
//  oZero and oBranchAddr are computed from the same operands as oAluResult and registered with it.
// TESTING
//  1. rst=1 for 2 clk mid-MUL -> every output 0, oStall 0, state IDLE after release.
//  2. R add 7+(-3), RegDst=1, rd=9 -> next edge: oAluResult=4, oWriteReg=9, oValid=1, oZero=0.
//  3. beq: AluOP=001, 5-5, iAddPC=0x100, imm=-2 -> oZero=1, oBranchAddr=0xF8, oBranch=1.
//  4. MUL -6 * 7 -> oStall high for 32 cycles; result -42 (0xFFFFFFD6) valid 33 edges after presentation; bubbles before.
//  5. MUL with iFlush at iteration 10 -> oStall drops that cycle; next edge bubble; following add completes normally.
//  6. Back-to-back: add, slt(-1<1), nor(0,0), unknown funct -> results 1-cycle each: sum, 1, 0xFFFFFFFF, 0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Decodes ALU control, computes ALU result, zero flag, branch target and
// destination register, and registers them into the EX/MEM outputs.
// MUL runs as a WIDTH-iteration shift-add; while it runs, ID/EX is stalled
// and bubbles are written into EX/MEM.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   iValid, iFlush        ID/EX holds an instruction / kill current EX work
//   iRegWrite..iBranch    control bits from ID/EX
//   iAluOP, iALUSrc       ALU operation select, operand-B select
//   iRegDst               1 = rd (iInstr1511), 0 = rt (iInstr2016)
//   iAddPC, iData1, iData2, iSignExtend, iInstr2016, iInstr1511  ID/EX data
//   oStall                combinational hold request to ID/EX and earlier
//   oValid..oBranch       EX/MEM control (all 0 on a bubble)
//   oBranchAddr, oZero, oAluResult, oData2, oWriteReg  EX/MEM data
//   oState                current FSM state (0 = IDLE, 1 = MUL)
//
// Stall semantics: while oStall is 1 the upstream stages must present the
// same ID/EX contents on the next cycle; when oStall is 0 at a rising edge,
// the instruction currently presented is consumed at that edge.
module ex_stage #(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iValid,
    input  logic             iFlush,
    input  logic             iRegWrite,
    input  logic             iMemToReg,
    input  logic             iMemWrite,
    input  logic             iMemRead,
    input  logic             iBranch,
    input  logic [2:0]       iAluOP,
    input  logic             iALUSrc,
    input  logic             iRegDst,
    input  logic [WIDTH-1:0] iAddPC,
    input  logic [WIDTH-1:0] iData1,
    input  logic [WIDTH-1:0] iData2,
    input  logic [WIDTH-1:0] iSignExtend,
    input  logic [RW-1:0]    iInstr2016,
    input  logic [RW-1:0]    iInstr1511,
    output logic             oStall,
    output logic             oValid,
    output logic             oRegWrite,
    output logic             oMemToReg,
    output logic             oMemWrite,
    output logic             oMemRead,
    output logic             oBranch,
    output logic [WIDTH-1:0] oBranchAddr,
    output logic             oZero,
    output logic [WIDTH-1:0] oAluResult,
    output logic [WIDTH-1:0] oData2,
    output logic [RW-1:0]    oWriteReg,
    output logic             oState
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t           state, stateNext;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mA, mB, acc, accNext;

    // control/data captured when a MUL starts
    logic             mRegWrite, mMemToReg, mMemWrite, mMemRead, mBranch;
    logic [RW-1:0]    mWriteReg;
    logic [WIDTH-1:0] mData2, mBranchAddr;

    logic [WIDTH-1:0] opB, aluRes, branchAddr;
    logic [5:0]       funct;
    logic             isMul, stallRaw, ldAlu, ldMul, startMul;

    assign funct      = iSignExtend[5:0];
    assign opB        = iALUSrc ? iSignExtend : iData2;
    assign branchAddr = iAddPC + (iSignExtend << 2);
    assign isMul      = (iAluOP == 3'b010) && (funct == 6'b011000);
    assign accNext    = acc + (mB[0] ? mA : '0);
    assign oState     = state;
    // reset overrides the combinational stall so the stage reads idle
    assign oStall     = stallRaw & ~rst;

    always_comb begin
        aluRes = '0;
        case (iAluOP)
            3'b000: aluRes = iData1 + opB;
            3'b001: aluRes = iData1 - opB;
            3'b010: begin
                case (funct)
                    6'b100000: aluRes = iData1 + opB;
                    6'b100010: aluRes = iData1 - opB;
                    6'b100100: aluRes = iData1 & opB;
                    6'b100101: aluRes = iData1 | opB;
                    6'b100111: aluRes = ~(iData1 | opB);
                    6'b101010: aluRes = {{(WIDTH-1){1'b0}}, $signed(iData1) < $signed(opB)};
                    default:   aluRes = '0;
                endcase
            end
            3'b011: aluRes = iData1 & opB;
            3'b100: aluRes = iData1 | opB;
            3'b101: aluRes = {{(WIDTH-1){1'b0}}, $signed(iData1) < $signed(opB)};
            default: aluRes = iData1 + opB;
        endcase
    end

    always_comb begin
        stateNext = state;
        stallRaw  = 1'b0;
        ldAlu     = 1'b0;
        ldMul     = 1'b0;
        startMul  = 1'b0;
        case (state)
            IDLE: begin
                if (iFlush || !iValid) begin
                    stateNext = IDLE;
                end else if (isMul) begin
                    stallRaw  = 1'b1;
                    startMul  = 1'b1;
                    stateNext = MUL;
                end else begin
                    ldAlu = 1'b1;
                end
            end
            MUL: begin
                if (iFlush) begin
                    stateNext = IDLE;
                end else if (cnt == LAST) begin
                    // ID/EX advances on the same edge the product is written
                    ldMul     = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stallRaw = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mA          <= '0;
            mB          <= '0;
            acc         <= '0;
            mRegWrite   <= 1'b0;
            mMemToReg   <= 1'b0;
            mMemWrite   <= 1'b0;
            mMemRead    <= 1'b0;
            mBranch     <= 1'b0;
            mWriteReg   <= '0;
            mData2      <= '0;
            mBranchAddr <= '0;
            oValid      <= 1'b0;
            oRegWrite   <= 1'b0;
            oMemToReg   <= 1'b0;
            oMemWrite   <= 1'b0;
            oMemRead    <= 1'b0;
            oBranch     <= 1'b0;
            oBranchAddr <= '0;
            oZero       <= 1'b0;
            oAluResult  <= '0;
            oData2      <= '0;
            oWriteReg   <= '0;
        end else begin
            state <= stateNext;

            if (startMul) begin
                mA          <= iData1;
                mB          <= opB;
                acc         <= '0;
                cnt         <= '0;
                mRegWrite   <= iRegWrite;
                mMemToReg   <= iMemToReg;
                mMemWrite   <= iMemWrite;
                mMemRead    <= iMemRead;
                mBranch     <= iBranch;
                mWriteReg   <= iInstr1511;
                mData2      <= iData2;
                mBranchAddr <= branchAddr;
            end else if (state == MUL) begin
                acc <= accNext;
                mA  <= mA << 1;
                mB  <= mB >> 1;
                cnt <= cnt + 1'b1;
            end

            if (ldAlu) begin
                oValid      <= 1'b1;
                oRegWrite   <= iRegWrite;
                oMemToReg   <= iMemToReg;
                oMemWrite   <= iMemWrite;
                oMemRead    <= iMemRead;
                oBranch     <= iBranch;
                oBranchAddr <= branchAddr;
                oZero       <= (aluRes == '0);
                oAluResult  <= aluRes;
                oData2      <= iData2;
                oWriteReg   <= iRegDst ? iInstr1511 : iInstr2016;
            end else if (ldMul) begin
                oValid      <= 1'b1;
                oRegWrite   <= mRegWrite;
                oMemToReg   <= mMemToReg;
                oMemWrite   <= mMemWrite;
                oMemRead    <= mMemRead;
                oBranch     <= mBranch;
                oBranchAddr <= mBranchAddr;
                oZero       <= (accNext == '0);
                oAluResult  <= accNext;
                oData2      <= mData2;
                oWriteReg   <= mWriteReg;
            end else begin
                // bubble: control cleared, data outputs hold
                oValid    <= 1'b0;
                oRegWrite <= 1'b0;
                oMemToReg <= 1'b0;
                oMemWrite <= 1'b0;
                oMemRead  <= 1'b0;
                oBranch   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: reset, ALU ops, branch target, MUL
// latency/stall, MUL flush and back-to-back single-cycle instructions.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        iValid, iFlush, iRegWrite, iMemToReg, iMemWrite, iMemRead, iBranch;
    logic [2:0]  iAluOP;
    logic        iALUSrc, iRegDst;
    logic [31:0] iAddPC, iData1, iData2, iSignExtend;
    logic [4:0]  iInstr2016, iInstr1511;
    logic        oStall, oValid, oRegWrite, oMemToReg, oMemWrite, oMemRead, oBranch;
    logic [31:0] oBranchAddr, oAluResult, oData2;
    logic        oZero;
    logic [4:0]  oWriteReg;
    logic        oState;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    ex_stage #(.WIDTH(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .iValid(iValid), .iFlush(iFlush),
        .iRegWrite(iRegWrite), .iMemToReg(iMemToReg), .iMemWrite(iMemWrite),
        .iMemRead(iMemRead), .iBranch(iBranch), .iAluOP(iAluOP),
        .iALUSrc(iALUSrc), .iRegDst(iRegDst), .iAddPC(iAddPC),
        .iData1(iData1), .iData2(iData2), .iSignExtend(iSignExtend),
        .iInstr2016(iInstr2016), .iInstr1511(iInstr1511), .oStall(oStall),
        .oValid(oValid), .oRegWrite(oRegWrite), .oMemToReg(oMemToReg),
        .oMemWrite(oMemWrite), .oMemRead(oMemRead), .oBranch(oBranch),
        .oBranchAddr(oBranchAddr), .oZero(oZero), .oAluResult(oAluResult),
        .oData2(oData2), .oWriteReg(oWriteReg), .oState(oState)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drv_idle();
        iValid = 0; iFlush = 0; iRegWrite = 0; iMemToReg = 0; iMemWrite = 0;
        iMemRead = 0; iBranch = 0; iAluOP = 3'b000; iALUSrc = 0; iRegDst = 0;
        iAddPC = 0; iData1 = 0; iData2 = 0; iSignExtend = 0; iInstr2016 = 0; iInstr1511 = 0;
    endtask

    task automatic drv_op(input logic [2:0] op, input logic src, input logic dst,
                          input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd,
                          input logic br);
        iValid = 1; iFlush = 0; iAluOP = op; iALUSrc = src; iRegDst = dst;
        iAddPC = pc; iData1 = d1; iData2 = d2; iSignExtend = imm;
        iInstr2016 = rt; iInstr1511 = rd; iBranch = br; iRegWrite = ~br;
        iMemToReg = 0; iMemWrite = 0; iMemRead = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // back-to-back vector table: op, ALUSrc, RegDst, d1, d2, imm, expected result, expected dest
    logic [2:0]  t_op [10] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b011, 3'b100, 3'b110, 3'b101, 3'b010};
    logic        t_src[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic        t_dst[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    logic [31:0] t_d1 [10] = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'd5, 32'd100, 32'h0000F0F0,
                               32'h0000F0F0, 32'd1, 32'd5, 32'd3};
    logic [31:0] t_d2 [10] = '{32'd3, 32'd1, 32'd0, 32'd6, 32'd0, 32'h0000FF00,
                               32'h0000FF00, 32'd2, 32'hFFFFFFFF, 32'd5};
    logic [31:0] t_imm[10] = '{32'h20, 32'h2A, 32'h27, 32'h3F, 32'h10, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h22};
    logic [31:0] t_res[10] = '{32'd5, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd116, 32'h0000F000,
                               32'h0000FFF0, 32'd3, 32'd0, 32'hFFFFFFFE};
    logic [4:0]  t_wr [10] = '{5'd11, 5'd11, 5'd11, 5'd11, 5'd4, 5'd11, 5'd11, 5'd11, 5'd11, 5'd11};

    initial begin
        int n;
        int stalls;
        logic [31:0] e;

        drv_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_result", oAluResult, 32'd0);
        check("rst_state", {31'd0, oState}, 32'd0);
        check("rst_stall", {31'd0, oStall}, 32'd0);

        // reset in the middle of a MUL
        drv_op(3'b010, 0, 1, 32'h0, 32'd3, 32'd3, 32'h18, 5'd1, 5'd2, 0);
        repeat (5) step();
        check("mul_pre_rst_state", {31'd0, oState}, 32'd1);
        rst = 1;
        #1;
        check("rst_mid_stall", {31'd0, oStall}, 32'd0);
        repeat (2) step();
        check("rst_mid_valid", {31'd0, oValid}, 32'd0);
        check("rst_mid_result", oAluResult, 32'd0);
        check("rst_mid_wr", {27'd0, oWriteReg}, 32'd0);
        check("rst_mid_baddr", oBranchAddr, 32'd0);
        drv_idle();
        rst = 0;
        #1;
        check("rst_mid_state", {31'd0, oState}, 32'd0);
        step();
        check("post_rst_valid", {31'd0, oValid}, 32'd0);

        // R-type add 7 + (-3) -> rd 9
        drv_op(3'b010, 0, 1, 32'h0, 32'd7, 32'hFFFFFFFD, 32'h20, 5'd3, 5'd9, 0);
        #1;
        check("add_stall", {31'd0, oStall}, 32'd0);
        step();
        check("add_res", oAluResult, 32'd4);
        check("add_wr", {27'd0, oWriteReg}, 32'd9);
        check("add_valid", {31'd0, oValid}, 32'd1);
        check("add_zero", {31'd0, oZero}, 32'd0);
        check("add_regwrite", {31'd0, oRegWrite}, 32'd1);

        // beq 5-5, target 0x100 + (-2 << 2)
        drv_op(3'b001, 0, 0, 32'h100, 32'd5, 32'd5, 32'hFFFFFFFE, 5'd3, 5'd9, 1);
        step();
        check("beq_zero", {31'd0, oZero}, 32'd1);
        check("beq_baddr", oBranchAddr, 32'h000000F8);
        check("beq_branch", {31'd0, oBranch}, 32'd1);
        check("beq_regwrite", {31'd0, oRegWrite}, 32'd0);

        // MUL -6 * 7 with 33-edge latency
        drv_op(3'b010, 0, 1, 32'h0, 32'hFFFFFFFA, 32'd7, 32'h18, 5'd6, 5'd10, 0);
        n = 0;
        stalls = 0;
        #1;
        while (n < 40) begin
            if (oStall) stalls++;
            step();
            n++;
            if (oValid) break;
        end
        drv_idle();
        check("mul_stalls", stalls, 32'd32);
        check("mul_latency", n, 32'd33);
        check("mul_res", oAluResult, 32'hFFFFFFD6);
        check("mul_wr", {27'd0, oWriteReg}, 32'd10);
        check("mul_data2", oData2, 32'd7);
        check("mul_zero", {31'd0, oZero}, 32'd0);
        #1;
        check("mul_after_stall", {31'd0, oStall}, 32'd0);
        check("mul_after_state", {31'd0, oState}, 32'd0);

        // MUL aborted by flush at iteration 10
        drv_op(3'b010, 0, 1, 32'h0, 32'd3, 32'd5, 32'h18, 5'd6, 5'd12, 0);
        repeat (11) step();
        check("mflush_stall_before", {31'd0, oStall}, 32'd1);
        check("mflush_valid_before", {31'd0, oValid}, 32'd0);
        iFlush = 1;
        #1;
        check("mflush_stall", {31'd0, oStall}, 32'd0);
        step();
        check("mflush_bubble", {31'd0, oValid}, 32'd0);
        check("mflush_state", {31'd0, oState}, 32'd0);
        drv_op(3'b010, 0, 1, 32'h0, 32'd10, 32'd20, 32'h20, 5'd6, 5'd13, 0);
        step();
        check("mflush_add_res", oAluResult, 32'd30);
        check("mflush_add_valid", {31'd0, oValid}, 32'd1);
        check("mflush_add_wr", {27'd0, oWriteReg}, 32'd13);

        // back-to-back single-cycle instructions through the scoreboard
        for (int i = 0; i < 10; i++) begin
            drv_op(t_op[i], t_src[i], t_dst[i], 32'h0, t_d1[i], t_d2[i], t_imm[i], 5'd4, 5'd11, 0);
            exp_q.push_back(t_res[i]);
            step();
            e = exp_q.pop_front();
            check($sformatf("b2b_res_%0d", i), oAluResult, e);
            check($sformatf("b2b_valid_%0d", i), {31'd0, oValid}, 32'd1);
            check($sformatf("b2b_wr_%0d", i), {27'd0, oWriteReg}, {27'd0, t_wr[i]});
            check($sformatf("b2b_zero_%0d", i), {31'd0, oZero}, {31'd0, (e == 32'd0)});
        end

        // flush with a valid non-MUL -> bubble
        drv_op(3'b000, 0, 1, 32'h0, 32'd1, 32'd1, 32'h0, 5'd4, 5'd11, 0);
        iFlush = 1;
        step();
        check("flush_valid", {31'd0, oValid}, 32'd0);
        check("flush_regwrite", {31'd0, oRegWrite}, 32'd0);

        // plain bubble
        drv_idle();
        step();
        check("bubble_valid", {31'd0, oValid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
